// File: rtl/regfile_ctrl_pkg.sv
// Shared types and default widths for the button-driven register-file writer.
package regfile_ctrl_pkg;

  // Default widths match the small demo register file (16 x 4-bit is overkill;
  // 4 entries of 4 bits is what the board exposes on switches/LEDs).
  localparam int DEFAULT_DATA_WIDTH = 4;
  localparam int DEFAULT_ADDR_WIDTH = 2;

  // Controller states: wait for a press, issue the one-cycle write, then
  // wait for every button to be released before accepting another press.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    HOLD  = 2'd2
  } state_t;

endpackage

// File: rtl/debouncer.sv
// Two-flop synchronizer, stability-count debouncer and rising-edge detector
// for one raw mechanical button.
//
// Output handshake: 'level' is the accepted (debounced) button level; 'press'
// is a single-cycle strobe, high for exactly one clock, registered one cycle
// after 'level' goes 0->1. There is no ready/back-pressure: a strobe that the
// consumer does not act on in that cycle is simply dropped.
module debouncer #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt;
  logic          level_d;

  // Synchronize, count consecutive disagreeing samples, flip the level once
  // the count is satisfied, and strobe on a debounced rising edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q  <= 2'b00;
      cnt     <= '0;
      level   <= 1'b0;
      level_d <= 1'b0;
      press   <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], raw};
      level_d <= level;
      press   <= level & ~level_d;
      if (sync_q[1] == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= sync_q[1];
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/button_write_ctrl.sv
// Turns two bouncing push-buttons into register-file write-port controls:
// 'write' latches the switches and pulses WE once, 'next' advances the address.
module button_write_ctrl
  import regfile_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH      = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH      = DEFAULT_ADDR_WIDTH,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  btn_write,
  input  logic                  btn_next,
  input  logic [DATA_WIDTH-1:0] sw,
  output logic                  WE,
  output logic [ADDR_WIDTH-1:0] A,
  output logic [DATA_WIDTH-1:0] WD,
  output logic                  busy
);

  // Current controller state; kept as a plainly named signal so checkers can
  // bind to it directly.
  state_t state;

  logic write_level;
  logic write_press;
  logic next_level;
  logic next_press;

  debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_db_write (
    .clk   (clk),
    .reset (reset),
    .raw   (btn_write),
    .level (write_level),
    .press (write_press)
  );

  debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_db_next (
    .clk   (clk),
    .reset (reset),
    .raw   (btn_next),
    .level (next_level),
    .press (next_press)
  );

  // Controller: write wins over next; HOLD blocks auto-repeat until both
  // buttons are released. WE, A and WD are registered alongside the state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      WE    <= 1'b0;
      A     <= '0;
      WD    <= '0;
    end else begin
      case (state)
        IDLE: begin
          WE <= 1'b0;
          if (write_press) begin
            WD    <= sw;
            WE    <= 1'b1;
            state <= WRITE;
          end else if (next_press) begin
            A     <= A + ADDR_WIDTH'(1);
            state <= HOLD;
          end
        end
        WRITE: begin
          WE    <= 1'b0;
          state <= HOLD;
        end
        HOLD: begin
          WE <= 1'b0;
          if (!write_level && !next_level) begin
            state <= IDLE;
          end
        end
        default: begin
          WE    <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_button_write_ctrl.sv
// Bench for button_write_ctrl with a short debounce window. A cycle-level
// reference model built from the button/controller rules is compared against
// WE, A, WD and busy every clock; directed scenarios add latency and
// scenario-level checks, followed by a randomized button/switch phase.
module tb_button_write_ctrl;

  localparam int N  = 4;
  localparam int DW = 4;
  localparam int AW = 2;

  logic          clk;
  logic          reset;
  logic          btn_write;
  logic          btn_next;
  logic [DW-1:0] sw;
  logic          WE;
  logic [AW-1:0] A;
  logic [DW-1:0] WD;
  logic          busy;

  int n_checks;
  int n_fail;
  int cyc;
  int pulses;
  int pulse_a;
  int pulse_wd;
  int first_we_cyc;

  // reference model state
  bit rh[2][$];
  bit sh[2][$];
  bit lh[2][$];
  int m_mode;
  bit m_we;
  int m_a;
  int m_wd;

  button_write_ctrl #(
    .DATA_WIDTH      (DW),
    .ADDR_WIDTH      (AW),
    .DEBOUNCE_CYCLES (N)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .btn_write (btn_write),
    .btn_next  (btn_next),
    .sw        (sw),
    .WE        (WE),
    .A         (A),
    .WD        (WD),
    .busy      (busy)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int b = 0; b < 2; b++) begin
      rh[b].delete();
      sh[b].delete();
      lh[b].delete();
    end
    m_mode = 0;
    m_we   = 1'b0;
    m_a    = 0;
    m_wd   = 0;
  endtask

  // One rising edge of the reference model, using the inputs present at it.
  task automatic model_step();
    bit raw[2];
    bit pr[2];
    bit lv[2];
    bit s;
    bit all_diff;
    int n;
    raw[0] = btn_write;
    raw[1] = btn_next;
    if (reset) begin
      model_reset();
      return;
    end
    for (int b = 0; b < 2; b++) begin
      n = lh[b].size();
      // accepted level before this edge, and whether it rose two edges ago
      lv[b] = (n >= 1) ? lh[b][n-1] : 1'b0;
      pr[b] = (n >= 2) && lh[b][n-2] && !((n >= 3) ? lh[b][n-3] : 1'b0);
      // raw seen through two flops: the value sampled two edges earlier
      rh[b].push_back(raw[b]);
      s = (rh[b].size() >= 3) ? rh[b][rh[b].size()-3] : 1'b0;
      sh[b].push_back(s);
      // accept a change only when the last N samples all disagree with it
      all_diff = (sh[b].size() >= N);
      if (all_diff) begin
        for (int j = 1; j <= N; j++) begin
          if (sh[b][sh[b].size()-j] == lv[b]) all_diff = 1'b0;
        end
      end
      lh[b].push_back(all_diff ? !lv[b] : lv[b]);
      if (rh[b].size() > 16) void'(rh[b].pop_front());
      if (sh[b].size() > 16) void'(sh[b].pop_front());
      if (lh[b].size() > 16) void'(lh[b].pop_front());
    end
    case (m_mode)
      0: begin
        m_we = 1'b0;
        if (pr[0]) begin
          m_wd   = int'(sw);
          m_we   = 1'b1;
          m_mode = 1;
        end else if (pr[1]) begin
          m_a    = (m_a + 1) % (1 << AW);
          m_mode = 2;
        end
      end
      1: begin
        m_we   = 1'b0;
        m_mode = 2;
      end
      default: begin
        m_we = 1'b0;
        if (!lv[0] && !lv[1]) m_mode = 0;
      end
    endcase
  endtask

  // Advance one clock, step the model, compare on the falling edge.
  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    cyc++;
    check("we", 32'(WE), 32'(m_we));
    check("addr", 32'(A), 32'(m_a));
    check("wd", 32'(WD), 32'(m_wd));
    check("busy", 32'(busy), 32'(m_mode != 0));
    if (WE === 1'b1) begin
      pulses++;
      pulse_a  = int'(A);
      pulse_wd = int'(WD);
      if (first_we_cyc < 0) first_we_cyc = cyc;
    end
  endtask

  task automatic run(input int n_cyc);
    for (int i = 0; i < n_cyc; i++) cycle();
  endtask

  // Wait for the controller to return to IDLE; returns cycles taken or -1.
  task automatic wait_idle(input int limit, output int taken);
    taken = -1;
    for (int i = 1; i <= limit; i++) begin
      cycle();
      if (busy === 1'b0 && m_mode == 0) begin
        taken = i;
        break;
      end
    end
    check("idle_timeout", 32'(taken > 0), 32'd1);
  endtask

  task automatic clear_pulses();
    pulses       = 0;
    pulse_a      = -1;
    pulse_wd     = -1;
    first_we_cyc = -1;
  endtask

  initial begin
    int start;
    int taken;
    int exp_seq[5];
    int a_before;
    bit hit;
    n_checks  = 0;
    n_fail    = 0;
    cyc       = 0;
    btn_write = 1'b0;
    btn_next  = 1'b0;
    sw        = '0;
    reset     = 1'b1;
    model_reset();
    clear_pulses();

    // reset state
    #1;
    check("rst_we", 32'(WE), 32'd0);
    check("rst_a", 32'(A), 32'd0);
    check("rst_wd", 32'(WD), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    run(3);
    reset = 1'b0;
    run(3);

    // clean write: latency, data, address, release-to-idle
    clear_pulses();
    sw = 4'h7;
    btn_write = 1'b1;
    start = cyc;
    run(20);
    check("clean_pulses", 32'(pulses), 32'd1);
    check("clean_latency", 32'(first_we_cyc - start), 32'(2 + N + 2));
    check("clean_wd", 32'(pulse_wd), 32'h7);
    check("clean_a", 32'(pulse_a), 32'd0);
    sw = 4'h2;
    btn_write = 1'b0;
    wait_idle(40, taken);
    check("clean_release", 32'(taken), 32'(2 + N + 1));
    check("clean_wd_kept", 32'(WD), 32'h7);
    run(5);

    // bounce: 12 clocks toggling every 2, then stable high
    clear_pulses();
    sw = 4'h3;
    for (int i = 0; i < 12; i++) begin
      btn_write = ((i / 2) % 2 == 0);
      cycle();
    end
    check("bounce_none", 32'(pulses), 32'd0);
    btn_write = 1'b1;
    run(20);
    check("bounce_one", 32'(pulses), 32'd1);
    check("bounce_wd", 32'(pulse_wd), 32'h3);
    btn_write = 1'b0;
    wait_idle(40, taken);
    run(5);

    // address wrap with five separate next presses
    clear_pulses();
    exp_seq = '{1, 2, 3, 0, 1};
    for (int p = 0; p < 5; p++) begin
      btn_next = 1'b1;
      run(10);
      btn_next = 1'b0;
      run(10);
      check("wrap_addr", 32'(A), 32'(exp_seq[p]));
    end
    check("wrap_no_we", 32'(pulses), 32'd0);

    // simultaneous presses: write wins, address untouched
    clear_pulses();
    a_before = int'(A);
    sw = 4'hA;
    btn_write = 1'b1;
    btn_next  = 1'b1;
    run(12);
    btn_write = 1'b0;
    btn_next  = 1'b0;
    wait_idle(40, taken);
    run(10);
    check("simul_pulses", 32'(pulses), 32'd1);
    check("simul_wd", 32'(pulse_wd), 32'hA);
    check("simul_a", 32'(A), 32'(a_before));

    // next pressed while write still held is ignored
    clear_pulses();
    a_before = int'(A);
    sw = 4'h6;
    btn_write = 1'b1;
    run(12);
    btn_next = 1'b1;
    run(10);
    btn_next = 1'b0;
    run(10);
    check("hold_a_kept", 32'(A), 32'(a_before));
    btn_write = 1'b0;
    wait_idle(40, taken);
    run(3);
    btn_next = 1'b1;
    run(10);
    btn_next = 1'b0;
    wait_idle(40, taken);
    check("hold_a_next", 32'(A), 32'((a_before + 1) % 4));
    check("hold_pulses", 32'(pulses), 32'd1);

    // reset asserted inside the WRITE cycle
    sw = 4'h5;
    btn_write = 1'b1;
    hit = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (m_we) begin
        hit = 1'b1;
        break;
      end
    end
    check("rstw_reached", 32'(hit), 32'd1);
    reset = 1'b1;
    #1;
    check("rstw_we", 32'(WE), 32'd0);
    check("rstw_a", 32'(A), 32'd0);
    check("rstw_wd", 32'(WD), 32'd0);
    check("rstw_busy", 32'(busy), 32'd0);
    model_reset();
    btn_write = 1'b0;
    run(2);
    reset = 1'b0;
    clear_pulses();
    run(20);
    check("rstw_no_we", 32'(pulses), 32'd0);

    // button held through reset release is a fresh press
    reset = 1'b1;
    sw = 4'h9;
    btn_write = 1'b1;
    run(2);
    reset = 1'b0;
    clear_pulses();
    run(15);
    check("heldrst_pulses", 32'(pulses), 32'd1);
    check("heldrst_wd", 32'(pulse_wd), 32'h9);
    btn_write = 1'b0;
    wait_idle(40, taken);

    // randomized buttons and switches against the model
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 7) == 0) btn_write = ~btn_write;
      if ($urandom_range(0, 7) == 0) btn_next  = ~btn_next;
      sw = DW'($urandom_range(0, 15));
      cycle();
    end
    btn_write = 1'b0;
    btn_next  = 1'b0;
    wait_idle(60, taken);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
